// File: rtl/clock_divider.sv
// Integer clock divider with 50% duty cycle for even and odd ratios.
// Odd ratios stretch the high phase by half an input period with a negedge copy of p.
module clock_divider #(
  parameter int DIVISOR = 5
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic clk_out
);

  localparam int unsigned CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned HALF = (DIVISOR > 1) ? DIVISOR / 2 : 0;
  localparam int unsigned LAST = (DIVISOR > 1) ? DIVISOR - 1 : 0;

  if (DIVISOR < 1) begin : g_bad
    $error("clock_divider: DIVISOR must be >= 1, got %0d", DIVISOR);
    assign clk_out = 1'b0;
  end else if (DIVISOR == 1) begin : g_pass
    assign clk_out = clk_in & rst_n;
  end else begin : g_div
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          run;
    logic          p;

    // run is low only until the first edge after reset, so that edge lands on cnt=0
    always_comb begin
      cnt_next = '0;
      if (run && (cnt != CW'(LAST))) begin
        cnt_next = cnt + CW'(1);
      end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        run <= 1'b0;
        p   <= 1'b0;
      end else begin
        cnt <= cnt_next;
        run <= 1'b1;
        p   <= (cnt_next < CW'(HALF));
      end
    end

    if ((DIVISOR % 2) == 0) begin : g_even
      assign clk_out = p;
    end else begin : g_odd
      logic q;

      // q trails p by half a period; p and q never toggle on the same edge
      always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
          q <= 1'b0;
        end else begin
          q <= p;
        end
      end

      assign clk_out = p | q;
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench for clock_divider: five ratios share one clock and reset;
// every clk_out transition is checked against a precomputed (level, time) queue.
`timescale 1ns/1ps
module tb_clock_divider;

  localparam longint T_CLK = 1000;
  localparam longint T_REL1 = 3200;     // first release; next rising edge at 3500
  localparam longint R1     = 3500;
  localparam longint T_ASRT = 65200;    // mid-period reset: 1700 ns into a common period
  localparam longint T_REL2 = 68200;
  localparam longint R2     = 68500;
  localparam longint T_END  = 128200;

  logic       clk_in;
  logic       rst_n;
  logic [4:0] co;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic   lvl;
    longint t;
  } ev_t;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  clock_divider #(.DIVISOR(5)) u_d5 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(co[0]));
  clock_divider #(.DIVISOR(4)) u_d4 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(co[1]));
  clock_divider #(.DIVISOR(1)) u_d1 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(co[2]));
  clock_divider #(.DIVISOR(2)) u_d2 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(co[3]));
  clock_divider #(.DIVISOR(3)) u_d3 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(co[4]));

  initial begin
    clk_in = 1'b0;
    forever #(T_CLK / 2) clk_in = ~clk_in;
  end

  for (genvar g = 0; g < 5; g++) begin : g_sb
    localparam int D = (g == 0) ? 5 : (g == 1) ? 4 : (g == 2) ? 1 : (g == 3) ? 2 : 3;
    // period D*T, high exactly D/2 input periods (x.5 for odd D)
    localparam longint P = D * T_CLK;
    localparam longint H = (D / 2) * T_CLK + ((D % 2) != 0 ? T_CLK / 2 : 0);

    ev_t q[$];

    initial begin
      ev_t e;
      for (longint r = R1; r < T_ASRT; r += P) begin
        e.lvl = 1'b1; e.t = r;
        q.push_back(e);
        e.lvl = 1'b0; e.t = (r + H < T_ASRT) ? r + H : T_ASRT;
        q.push_back(e);
      end
      for (longint r = R2; r < T_END; r += P) begin
        e.lvl = 1'b1; e.t = r;
        q.push_back(e);
        if (r + H < T_END) begin
          e.lvl = 1'b0; e.t = r + H;
          q.push_back(e);
        end
      end
    end

    // monitor: every clk_out transition must match the head of the queue
    initial begin
      ev_t e;
      #1;
      forever begin
        @(co[g]);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL D%0d_unexpected_edge: got level %b at t=%0t, required no edge", D, co[g], $time);
        end else begin
          e = q.pop_front();
          check($sformatf("D%0d_edge_level", D), longint'(co[g]), longint'(e.lvl));
          check($sformatf("D%0d_edge_time", D), longint'($time), e.t);
        end
      end
    end

    initial begin
      #(T_END + 5);
      check($sformatf("D%0d_missing_edges", D), longint'(q.size()), 0);
    end
  end

  initial begin
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) check($sformatf("reset_low_dut%0d", i), longint'(co[i]), 0);
    #(T_REL1 - 1);
    rst_n = 1'b1;
    #(T_ASRT - T_REL1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) check($sformatf("async_reset_dut%0d", i), longint'(co[i]), 0);
    // clk_in is high here: pass-through must still be forced low
    #(66700 - T_ASRT - 1);
    for (int i = 0; i < 5; i++) check($sformatf("reset_hold_dut%0d", i), longint'(co[i]), 0);
    #(T_REL2 - 66700);
    rst_n = 1'b1;
    #(T_END - T_REL2 + 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
